// File: rtl/csr_access_arb_pkg.sv
// Shared types and constants for the machine-mode CSR access arbiter.
// Optional debug port is enabled with CSR_ARB_DBG_EN.
package csr_access_arb_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned IDX_W  = 12;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    CSR_OP_R  = 2'b00,
    CSR_OP_RW = 2'b01,
    CSR_OP_RS = 2'b10,
    CSR_OP_RC = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_e;

  localparam logic [IDX_W-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [IDX_W-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [IDX_W-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [IDX_W-1:0] CSR_MINSTRET = 12'hB02;

  typedef struct packed {
    logic              id;
    csr_op_e           op;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wdata;
  } csr_req_t;

endpackage

// File: rtl/csr_access_arb_if.sv
// Request, response and CSR-file signals of the CSR access arbiter.
// Port 1 signals exist only when CSR_ARB_DBG_EN is defined.
interface csr_access_arb_if;
  import csr_access_arb_pkg::*;

  logic              p0_valid;
  logic              p0_ready;
  logic [IDX_W-1:0]  p0_idx;
  logic [OP_W-1:0]   p0_op;
  logic [DATA_W-1:0] p0_wdata;
`ifdef CSR_ARB_DBG_EN
  logic              p1_valid;
  logic              p1_ready;
  logic [IDX_W-1:0]  p1_idx;
  logic [OP_W-1:0]   p1_op;
  logic [DATA_W-1:0] p1_wdata;
`endif

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [IDX_W-1:0]  csr_index;
  logic              csr_rd_en;
  logic [DATA_W-1:0] csr_rdata;
  logic              csr_hit;
  logic              csr_wr_en;
  logic [DATA_W-1:0] csr_wdata;

  modport slave (
    input  p0_valid, p0_idx, p0_op, p0_wdata,
    output p0_ready,
`ifdef CSR_ARB_DBG_EN
    input  p1_valid, p1_idx, p1_op, p1_wdata,
    output p1_ready,
`endif
    output rsp_valid, rsp_id, rsp_rdata, rsp_err,
    output csr_index, csr_rd_en, csr_wr_en, csr_wdata,
    input  csr_rdata, csr_hit
  );

  modport master (
    output p0_valid, p0_idx, p0_op, p0_wdata,
    input  p0_ready,
`ifdef CSR_ARB_DBG_EN
    output p1_valid, p1_idx, p1_op, p1_wdata,
    input  p1_ready,
`endif
    input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
    input  csr_index, csr_rd_en, csr_wr_en, csr_wdata,
    output csr_rdata, csr_hit
  );

endinterface

// File: rtl/csr_rmw_alu.sv
// Combinational CSR read-modify-write: produces the new CSR value from op, old value and operand.
module csr_rmw_alu
  import csr_access_arb_pkg::*;
(
  input  csr_op_e           op,
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] new_val
);

  always_comb begin
    new_val = old_val;
    unique case (op)
      CSR_OP_RW: new_val = operand;
      CSR_OP_RS: new_val = old_val | operand;
      CSR_OP_RC: new_val = old_val & ~operand;
      default:   new_val = old_val;
    endcase
  end

endmodule

// File: rtl/csr_access_arb.sv
// CSR request arbiter and read/modify/write sequencer (IDLE -> READ -> WRITE).
// CSR_ARB_DBG_EN adds the debug requester on port 1 with round-robin arbitration.
module csr_access_arb
  import csr_access_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  csr_access_arb_if.slave bus
);

  arb_state_e        state_q, state_d;
  csr_req_t          req_q, req_d;
  csr_req_t          grant_req;
  logic              grant_id;
  logic              hs;
  logic              idle;
  logic [DATA_W-1:0] new_val;

  logic [IDX_W-1:0]  csr_index_q, csr_index_d;
  logic              csr_rd_en_q, csr_rd_en_d;
  logic              csr_wr_en_q, csr_wr_en_d;
  logic [DATA_W-1:0] csr_wdata_q, csr_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic              err_q, err_d;

  // Ready is withheld while reset is asserted so nothing handshakes during reset.
  assign idle = (state_q == ST_IDLE) && !rst;

`ifdef CSR_ARB_DBG_EN
  logic last_q, last_d;
  logic gnt0, gnt1;

  // Port 1 wins when alone, or on conflict when port 0 was granted last.
  assign gnt1 = bus.p1_valid && (!bus.p0_valid || !last_q);
  assign gnt0 = bus.p0_valid && !gnt1;

  assign bus.p0_ready = idle && gnt0;
  assign bus.p1_ready = idle && gnt1;
  assign grant_id     = gnt1;
  assign hs           = idle && (gnt0 || gnt1);
  assign grant_req    = gnt1 ? '{id: 1'b1, op: csr_op_e'(bus.p1_op), idx: bus.p1_idx, wdata: bus.p1_wdata}
                             : '{id: 1'b0, op: csr_op_e'(bus.p0_op), idx: bus.p0_idx, wdata: bus.p0_wdata};

  always_comb begin
    last_d = last_q;
    if (hs) last_d = grant_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  assign bus.p0_ready = idle;
  assign grant_id     = 1'b0;
  assign hs           = idle && bus.p0_valid;
  assign grant_req    = '{id: 1'b0, op: csr_op_e'(bus.p0_op), idx: bus.p0_idx, wdata: bus.p0_wdata};
`endif

  csr_rmw_alu u_alu (
    .op      (req_q.op),
    .old_val (bus.csr_rdata),
    .operand (req_q.wdata),
    .new_val (new_val)
  );

  // Outputs are registered: each phase's strobes are computed in the preceding cycle.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    csr_index_d = '0;
    csr_rd_en_d = 1'b0;
    csr_wr_en_d = 1'b0;
    csr_wdata_d = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = 1'b0;
    old_d       = '0;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          req_d       = grant_req;
          state_d     = ST_READ;
          csr_index_d = grant_req.idx;
          csr_rd_en_d = 1'b1;
        end
      end
      ST_READ: begin
        state_d     = ST_WRITE;
        csr_index_d = req_q.idx;
        csr_wr_en_d = bus.csr_hit && (req_q.op != CSR_OP_R);
        csr_wdata_d = new_val;
        rsp_valid_d = 1'b1;
        rsp_id_d    = req_q.id;
        old_d       = bus.csr_hit ? bus.csr_rdata : '0;
        err_d       = !bus.csr_hit;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      csr_index_q <= '0;
      csr_rd_en_q <= 1'b0;
      csr_wr_en_q <= 1'b0;
      csr_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      old_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      csr_index_q <= csr_index_d;
      csr_rd_en_q <= csr_rd_en_d;
      csr_wr_en_q <= csr_wr_en_d;
      csr_wdata_q <= csr_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      old_q       <= old_d;
      err_q       <= err_d;
    end
  end

  assign bus.csr_index = csr_index_q;
  assign bus.csr_rd_en = csr_rd_en_q;
  assign bus.csr_wr_en = csr_wr_en_q;
  assign bus.csr_wdata = csr_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rdata = old_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: doc/csr_access_arb.md
# csr_access_arb

Sequencer and arbiter for the machine-mode CSR file. Accepts CSR read-modify-write requests from the core pipeline (port 0) and, optionally, the debug/difftest requester (port 1), and picks one with round-robin. It runs each request as a fixed three-phase read / modify / write sequence against the CSR file, then returns the old CSR value to the requester. It sits between the execute stage and the CSR storage, which provides a combinational read with a hit flag and a synchronous write.

## Interface
- DATA_W, 64, CSR data width
- IDX_W, 12, CSR index width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- p0_valid / p0_ready  in / out  1  port 0 request handshake
- p0_idx  in  IDX_W  target CSR index
- p0_op  in  2  00 read-only, 01 write (RW), 10 set (RS), 11 clear (RC)
- p0_wdata  in  DATA_W  write operand (rs1 value or zero-extended immediate)
- p1_valid, p1_ready, p1_idx, p1_op, p1_wdata  same as port 0; present only with CSR_ARB_DBG_EN
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  requester of the response (0/1); tied 0 without macro
- rsp_rdata  out  DATA_W  CSR value before the write
- rsp_err  out  1  CSR index not implemented
- csr_index  out  IDX_W  index to the CSR file
- csr_rd_en  out  1  read strobe
- csr_rdata  in  DATA_W  combinational read data
- csr_hit  in  1  index implemented
- csr_wr_en  out  1  write strobe, sampled by the CSR file on the same edge
- csr_wdata  out  DATA_W  new value

## Operation
- FSM states: IDLE, READ, WRITE. Reset enters IDLE.
- IDLE:
  - The arbiter grants one valid port.
  - On handshake (valid & ready), latch idx, op, wdata and id into request registers, then go to READ.
- READ:
  - Drive csr_index from the latched index and assert csr_rd_en.
  - Register csr_rdata into old_r and csr_hit into hit_r.
  - Go to WRITE.
- WRITE:
  - csr_wdata is the new value: op 01 gives wdata; op 10 gives old_r | wdata; op 11 gives old_r & ~wdata; op 00 gives old_r.
  - csr_wr_en = hit_r & (op != 00).
  - Assert rsp_valid with rsp_rdata = old_r (forced 0 when !hit_r), rsp_err = !hit_r, and rsp_id = latched id.
  - Go to IDLE.
- RS or RC with wdata == 0 still writes. The pipeline encodes the rs1=x0 no-write case as op 00.
- Arbitration:
  - last_r records the last granted port.
  - If both ports are valid, grant the port != last_r.
  - If one port is valid, grant it.
  - ready is asserted only in IDLE, and only to the granted port. ready may depend combinationally on valid.
- Requester rules:
  - Once valid is raised, hold valid and the payload stable until ready.
  - Responses are never back-pressured; the requester must accept rsp_valid.

## Timing
- Handshake at edge T. READ occupies cycle T+1. WRITE and rsp_valid occupy cycle T+2. The CSR write commits at the end of T+2.
- The next handshake is possible at the end of T+3 at the earliest, so throughput is one request per 3 cycles.
- A CSR that updates by itself (mcycle) can change between READ and WRITE. The RMW uses the READ-cycle value and the write wins.
- Reset values: state IDLE; last_r = 1, so port 0 wins the first conflict; request registers 0; every output 0.
- An asserted reset mid-sequence aborts immediately:
  - no csr_wr_en, no rsp_valid;
  - an in-flight request is dropped and the requester must reissue it.
- A request present during reset is not accepted until the first IDLE cycle after rst deasserts.

## Configuration
- CSR_ARB_DBG_EN defined:
  - port 1 exists;
  - round-robin arbitration is active;
  - rsp_id reports the requester.
- CSR_ARB_DBG_EN undefined:
  - port 1 is removed;
  - p0_ready = (state == IDLE);
  - last_r is removed;
  - rsp_id is constant 0.
- The FSM and timing are identical in both builds.

## Structure
- Shared defines header holds: CSR_OP_R/RW/RS/RC encodings, state encodings, DATA_W/IDX_W defaults, and CSR index constants (mcycle etc.).
- Sub-module csr_rmw_alu: combinational; inputs op, old value, operand; output new value. The CSR unit can reuse it.
- The FSM, arbiter and request registers stay in csr_access_arb.

## Test plan
- **Port 0 RW.** Stimulus: port 0 RW, idx 0xB00, wdata 0x55, CSR holds 0x10. Response: rsp_valid at T+2 with rdata 0x10; csr_wr_en with wdata 0x55 at T+2.
- **Port 0 RC.** Stimulus: port 0 RC, wdata 0x0F, old 0xFF. Response: csr_wdata 0xF0, rsp_rdata 0xFF.
- **Port 0 read-only.** Stimulus: port 0 op 00. Response: csr_wr_en stays 0; rsp_rdata is the CSR value.
- **Unimplemented index.** Stimulus: idx 0x7FF, csr_hit 0. Response: rsp_err 1, rsp_rdata 0, no write.
- **Conflict (DBG_EN).** Stimulus: both ports valid continuously from reset. Response: grants alternate 0,1,0,1, one every 3 cycles; rsp_id matches each grant.
- **Reset mid-sequence.** Stimulus: assert rst during READ. Response: all outputs 0 asynchronously; no write; the next request is accepted in the first IDLE cycle after release.
